// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide sequencing controller:
//   - controller state encoding
//   - unit select constants for the shared mul/div unit
//   - quotient returned for a divide by zero (unit bypassed)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DRAIN = 3'd4
    } muldiv_state_e;

    localparam logic UNIT_MUL = 1'b0;
    localparam logic UNIT_DIV = 1'b1;

    // Widest operand supported; narrower configurations take the low bits.
    localparam int MAX_XLEN = 64;

    // Quotient of x/0 is all ones; the remainder of x%0 is x itself.
    localparam logic [MAX_XLEN-1:0] DIV0_QUOTIENT = {MAX_XLEN{1'b1}};

endpackage : muldiv_pkg

// File: rtl/muldiv_timer.sv
// -----------------------------------------------------------------------------
// muldiv_timer
// Wait-cycle counter used to bound how long the controller waits for the unit.
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_clear   synchronous clear (takes priority over enable)
//   i_enable  count up by one this cycle
//   o_expire  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module muldiv_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    // A timeout of one cycle still needs a one-bit counter.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Cycle counter: cleared outside the waiting states, counts while enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CW{1'b0}};
        end else if (i_clear) begin
            r_count <= {CW{1'b0}};
        end else if (i_enable) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expire = (r_count == LAST);

endmodule : muldiv_timer

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequences M-extension requests onto a shared multiply/divide unit and writes
// the result back to the GPR file. Divide by zero is resolved locally.
// Ports:
//   clk, rst                     clock / synchronous active-high reset
//   mul_en, mul_operation        multiply request (0=mul, 1=mulh)
//   div_en, div_operation        divide request   (1=div, 0=rem)
//   rd_in, op_a, op_b            destination register and operands
//   flush                        pipeline kill
//   unit_start/sel/op/a/b        command to the shared unit
//   unit_done, unit_result       completion from the shared unit
//   stall                        freeze fetch/decode
//   wb_en, wb_sel, wb_data       GPR write port
//   busy, timeout, req_err       status
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_en,
    input  logic            mul_operation,
    input  logic            div_en,
    input  logic            div_operation,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            unit_start,
    output logic            unit_sel,
    output logic            unit_op,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    input  logic            unit_done,
    input  logic [XLEN-1:0] unit_result,
    output logic            stall,
    output logic            wb_en,
    output logic [4:0]      wb_sel,
    output logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            timeout,
    output logic            req_err
);

    muldiv_state_e   r_state;
    muldiv_state_e   w_next_state;

    logic            r_sel;
    logic            r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_result;
    logic            r_timeout;

    logic            w_req;
    logic            w_take_div;
    logic            w_div0;
    logic            w_timeout_hit;
    logic            w_tmr_run;
    logic            w_tmr_expire;

    assign w_req      = (mul_en | div_en) & ~flush;
    // When both decoders fire, the divide wins.
    assign w_take_div = div_en;
    assign w_div0     = w_take_div & (op_b == {XLEN{1'b0}});
    assign w_tmr_run  = (r_state == ST_WAIT) | (r_state == ST_DRAIN);

    muldiv_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clear  (~w_tmr_run),
        .i_enable (w_tmr_run),
        .o_expire (w_tmr_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; also flags a WAIT abort for the timeout pulse.
    always_comb begin
        w_next_state  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = w_div0 ? ST_WB : ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next_state = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    // If the unit already finished (or gave up) there is
                    // nothing left to drain.
                    w_next_state = (unit_done | w_tmr_expire) ? ST_IDLE : ST_DRAIN;
                end else if (unit_done) begin
                    w_next_state = ST_WB;
                end else if (w_tmr_expire) begin
                    w_next_state  = ST_IDLE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WB: begin
                w_next_state = ST_IDLE;
            end
            ST_DRAIN: begin
                if (unit_done | w_tmr_expire) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latches and write-back result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel    <= UNIT_MUL;
            r_op     <= 1'b0;
            r_a      <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_rd     <= 5'd0;
            r_result <= {XLEN{1'b0}};
        end else if ((r_state == ST_IDLE) && w_req) begin
            r_sel <= w_take_div ? UNIT_DIV : UNIT_MUL;
            r_op  <= w_take_div ? div_operation : mul_operation;
            r_a   <= op_a;
            r_b   <= op_b;
            r_rd  <= rd_in;
            if (w_div0) begin
                r_result <= div_operation ? DIV0_QUOTIENT[XLEN-1:0] : op_a;
            end else begin
                r_result <= {XLEN{1'b0}};
            end
        end else if ((r_state == ST_WAIT) && unit_done && !flush) begin
            r_result <= unit_result;
        end else begin
            r_result <= r_result;
        end
    end

    // Timeout pulse lands in the first IDLE cycle after the abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
        end
    end

    // Per-state strobes; flush kills unit_start and wb_en in the same cycle.
    always_comb begin
        unit_start = 1'b0;
        stall      = 1'b0;
        wb_en      = 1'b0;
        req_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall   = w_req;
                req_err = w_req & mul_en & div_en;
            end
            ST_ISSUE: begin
                unit_start = ~flush;
                stall      = 1'b1;
            end
            ST_WAIT: begin
                stall = 1'b1;
            end
            ST_DRAIN: begin
                stall = 1'b1;
            end
            ST_WB: begin
                wb_en = ~flush & (r_rd != 5'd0);
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign unit_sel = r_sel;
    assign unit_op  = r_op;
    assign unit_a   = r_a;
    assign unit_b   = r_b;
    assign wb_sel   = r_rd;
    assign wb_data  = r_result;
    assign busy     = (r_state != ST_IDLE);
    assign timeout  = r_timeout;

endmodule : muldiv_ctrl

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench: each transaction is expanded into a per-cycle table of
// inputs and expected outputs derived from the controller's latency rules;
// one loop drives the table and compares every cycle.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 64;

    logic            clk;
    logic            rst;
    logic            mul_en, mul_operation, div_en, div_operation;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] op_a, op_b;
    logic            flush;
    logic            unit_start, unit_sel, unit_op;
    logic [XLEN-1:0] unit_a, unit_b;
    logic            unit_done;
    logic [XLEN-1:0] unit_result;
    logic            stall, wb_en;
    logic [4:0]      wb_sel;
    logic [XLEN-1:0] wb_data;
    logic            busy, timeout, req_err;

    muldiv_ctrl #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mul_en        (mul_en),
        .mul_operation (mul_operation),
        .div_en        (div_en),
        .div_operation (div_operation),
        .rd_in         (rd_in),
        .op_a          (op_a),
        .op_b          (op_b),
        .flush         (flush),
        .unit_start    (unit_start),
        .unit_sel      (unit_sel),
        .unit_op       (unit_op),
        .unit_a        (unit_a),
        .unit_b        (unit_b),
        .unit_done     (unit_done),
        .unit_result   (unit_result),
        .stall         (stall),
        .wb_en         (wb_en),
        .wb_sel        (wb_sel),
        .wb_data       (wb_data),
        .busy          (busy),
        .timeout       (timeout),
        .req_err       (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        // stimulus
        logic        rst, mul_en, mul_op, div_en, div_op, flush, done;
        logic [4:0]  rd;
        logic [31:0] a, b, res;
        // expectations
        logic        chk;
        logic        e_start, e_stall, e_wb_en, e_busy, e_timeout, e_req_err;
        logic        chk_unit;
        logic        e_sel, e_op;
        logic [31:0] e_a, e_b;
        logic        chk_wb;
        logic [4:0]  e_wb_sel;
        logic [31:0] e_wb_data;
    } cyc_t;

    cyc_t        tbl[$];
    logic [31:0] wb_log[$];
    int          checks = 0;
    int          errors = 0;

    // Quiet cycle: no inputs, all strobes expected low.
    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.rst = 1'b0; c.mul_en = 1'b0; c.mul_op = 1'b0; c.div_en = 1'b0;
        c.div_op = 1'b0; c.flush = 1'b0; c.done = 1'b0; c.rd = 5'd0;
        c.a = 32'd0; c.b = 32'd0; c.res = 32'd0;
        c.chk = 1'b1;
        c.e_start = 1'b0; c.e_stall = 1'b0; c.e_wb_en = 1'b0; c.e_busy = 1'b0;
        c.e_timeout = 1'b0; c.e_req_err = 1'b0;
        c.chk_unit = 1'b0; c.e_sel = 1'b0; c.e_op = 1'b0; c.e_a = 32'd0; c.e_b = 32'd0;
        c.chk_wb = 1'b0; c.e_wb_sel = 5'd0; c.e_wb_data = 32'd0;
        return c;
    endfunction

    // Cycle where every output, including latched ones, must be zero.
    function automatic cyc_t zero_cyc();
        cyc_t c;
        c = idle_cyc();
        c.chk_unit = 1'b1;
        c.chk_wb   = 1'b1;
        return c;
    endfunction

    // Expand one request into its cycle table.
    //   done_wait : WAIT-relative cycle (1 = first WAIT) carrying unit_done, 0 = never
    //   flush_wait: -1 none, 0 flush in ISSUE, k flush on the k-th WAIT cycle
    //   rst_wait  : 0 none, k assert rst on the k-th WAIT cycle (stray done follows)
    task automatic op_seq(input logic m_en, input logic m_op, input logic d_en,
                          input logic d_op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int done_wait, input int flush_wait,
                          input logic [31:0] res, input int rst_wait);
        cyc_t c;
        logic sel, op;
        sel = d_en;
        op  = d_en ? d_op : m_op;

        // request cycle in IDLE
        c = idle_cyc();
        c.mul_en = m_en; c.mul_op = m_op; c.div_en = d_en; c.div_op = d_op;
        c.rd = rd; c.a = a; c.b = b;
        c.e_stall = 1'b1;
        c.e_req_err = m_en & d_en;
        tbl.push_back(c);

        if (d_en && (b == 32'd0)) begin
            // divide by zero: straight to write-back, unit untouched
            c = idle_cyc();
            c.e_busy = 1'b1;
            c.e_wb_en = (rd != 5'd0);
            c.chk_wb = 1'b1; c.e_wb_sel = rd;
            c.e_wb_data = d_op ? 32'hFFFF_FFFF : a;
            c.chk_unit = 1'b1; c.e_sel = sel; c.e_op = op; c.e_a = a; c.e_b = b;
            tbl.push_back(c);
        end else begin
            c = idle_cyc();
            c.flush = (flush_wait == 0);
            c.e_start = (flush_wait != 0);
            c.e_stall = 1'b1; c.e_busy = 1'b1;
            c.chk_unit = 1'b1; c.e_sel = sel; c.e_op = op; c.e_a = a; c.e_b = b;
            tbl.push_back(c);
            if (flush_wait != 0) begin
                for (int w = 1; w <= 200; w++) begin
                    c = idle_cyc();
                    c.e_stall = 1'b1; c.e_busy = 1'b1;
                    if (rst_wait > 0 && w == rst_wait) begin
                        c.rst = 1'b1;
                        tbl.push_back(c);
                        c = zero_cyc();
                        c.done = 1'b1; c.res = 32'hDEAD_BEEF;
                        tbl.push_back(c);
                        break;
                    end else if (done_wait > 0 && w == done_wait) begin
                        c.done = 1'b1; c.res = res;
                        tbl.push_back(c);
                        c = idle_cyc();
                        if (!(flush_wait > 0 && flush_wait < done_wait)) begin
                            c.e_busy = 1'b1;
                            c.e_wb_en = (rd != 5'd0);
                            c.chk_wb = 1'b1; c.e_wb_sel = rd; c.e_wb_data = res;
                        end
                        tbl.push_back(c);
                        break;
                    end else if (done_wait == 0 && w == TIMEOUT) begin
                        tbl.push_back(c);
                        c = idle_cyc();
                        c.e_timeout = 1'b1;
                        tbl.push_back(c);
                        break;
                    end else begin
                        c.flush = (w == flush_wait);
                        tbl.push_back(c);
                    end
                end
            end
        end
        tbl.push_back(idle_cyc());
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        cyc_t c;
        rst = 1'b1; mul_en = 1'b0; mul_operation = 1'b0; div_en = 1'b0;
        div_operation = 1'b0; rd_in = 5'd0; op_a = '0; op_b = '0; flush = 1'b0;
        unit_done = 1'b0; unit_result = '0;

        // power-on reset, then a cycle where everything must read zero
        c = idle_cyc(); c.rst = 1'b1; c.chk = 1'b0;
        tbl.push_back(c);
        tbl.push_back(c);
        tbl.push_back(zero_cyc());

        // mul 7*6 -> x5, done on 2nd WAIT cycle
        op_seq(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 5'd5, 2, -1, 32'd42, 0);
        // div by zero, then rem by zero
        op_seq(1'b0, 1'b0, 1'b1, 1'b1, 32'd100, 32'd0, 5'd3, 0, -1, 32'd0, 0);
        op_seq(1'b0, 1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 5'd3, 0, -1, 32'd0, 0);
        // mulh at minimum latency: 0x10000*0x10000 upper word = 1
        op_seq(1'b1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7, 1, -1, 32'd1, 0);
        // div flushed on 2nd WAIT cycle, unit finishes 4 cycles later
        op_seq(1'b0, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 5'd9, 6, 2, 32'd14, 0);
        // unit never answers -> timeout
        op_seq(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 5'd4, 0, -1, 32'd0, 0);
        // conflicting request: divide 50/5 taken, req_err
        op_seq(1'b1, 1'b0, 1'b1, 1'b1, 32'd50, 32'd5, 5'd6, 3, -1, 32'd10, 0);
        // rd = 0: full sequence, no write strobe
        op_seq(1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd11, 5'd0, 1, -1, 32'd99, 0);
        // flush in ISSUE, followed by a stray done in IDLE
        op_seq(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 5'd2, 0, 0, 32'd0, 0);
        c = idle_cyc(); c.done = 1'b1; c.res = 32'h5555_5555;
        tbl.push_back(c);
        // request masked by flush in IDLE
        c = idle_cyc(); c.mul_en = 1'b1; c.flush = 1'b1; c.rd = 5'd1;
        tbl.push_back(c);
        tbl.push_back(idle_cyc());
        // reset on the 3rd WAIT cycle, stray done afterwards
        op_seq(1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 32'd4, 5'd8, 0, -1, 32'd0, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            c = tbl[i];
            rst = c.rst; mul_en = c.mul_en; mul_operation = c.mul_op;
            div_en = c.div_en; div_operation = c.div_op; rd_in = c.rd;
            op_a = c.a; op_b = c.b; flush = c.flush;
            unit_done = c.done; unit_result = c.res;
            @(negedge clk);
            if (c.chk) begin
                check("unit_start", i, {31'd0, unit_start}, {31'd0, c.e_start});
                check("stall",      i, {31'd0, stall},      {31'd0, c.e_stall});
                check("wb_en",      i, {31'd0, wb_en},      {31'd0, c.e_wb_en});
                check("busy",       i, {31'd0, busy},       {31'd0, c.e_busy});
                check("timeout",    i, {31'd0, timeout},    {31'd0, c.e_timeout});
                check("req_err",    i, {31'd0, req_err},    {31'd0, c.e_req_err});
                if (c.chk_unit) begin
                    check("unit_sel", i, {31'd0, unit_sel}, {31'd0, c.e_sel});
                    check("unit_op",  i, {31'd0, unit_op},  {31'd0, c.e_op});
                    check("unit_a",   i, unit_a, c.e_a);
                    check("unit_b",   i, unit_b, c.e_b);
                end
                if (c.chk_wb) begin
                    check("wb_sel",  i, {27'd0, wb_sel}, {27'd0, c.e_wb_sel});
                    check("wb_data", i, wb_data, c.e_wb_data);
                end
            end
            if (wb_en === 1'b1) begin
                wb_log.push_back(wb_data);
            end
        end

        // hand-computed write-back sequence
        check("wb_count", -1, wb_log.size(), 32'd5);
        if (wb_log.size() == 5) begin
            check("wb_mul",   -1, wb_log[0], 32'd42);
            check("wb_div0",  -1, wb_log[1], 32'hFFFF_FFFF);
            check("wb_rem0",  -1, wb_log[2], 32'd100);
            check("wb_mulh",  -1, wb_log[3], 32'd1);
            check("wb_both",  -1, wb_log[4], 32'd10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_ctrl
